// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU controller and its mul/div engine.
// Pure declarations: no latency, no flow control.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_ORI  = 4'd8;
  localparam logic [3:0] ALU_BEQ  = 4'd9;
  localparam logic [3:0] ALU_BNE  = 4'd10;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_BNE   = 3'b011;
  localparam logic [2:0] OP_ORI   = 3'b100;
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_SLTI  = 3'b110;
  localparam logic [2:0] OP_SLTIU = 3'b111;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// DATA_W steps after start; no backpressure, the controller drives step every busy cycle.
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              last,
  output logic [DATA_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] q_nxt
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] acc, q, d;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   sum, trial;

  // Multiply: {acc,q} shifts right, q starts as the multiplier.
  // Divide: {acc,q} shifts left, q collects quotient bits, acc holds the remainder.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, d};
    trial   = {acc, q[DATA_W-1]} - {1'b0, d};
    acc_nxt = acc;
    q_nxt   = q;
    if (is_div) begin
      if (!trial[DATA_W]) begin
        acc_nxt = trial[DATA_W-1:0];
        q_nxt   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[DATA_W-2:0], q[DATA_W-1]};
        q_nxt   = {q[DATA_W-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_nxt = sum[DATA_W:1];
      q_nxt   = {sum[0], q[DATA_W-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[DATA_W-1:1]};
      q_nxt   = {acc[0], q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      q   <= op_a;
      d   <= op_b;
      cnt <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decode plus iterative mul/div engine owning HI/LO.
// Decode is combinational; mul/div holds stall_o for DATA_W+1 cycles from issue.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [3:0]        ALUCtrl_o,
  output logic              illegal_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] mf_data_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  md_state_e         state, state_nxt;
  logic              rtype_known, md_op, issue, start, wr, last;
  logic              div_code, sgn, neg1, neg2;
  logic              neg_a, neg_b, div0;
  logic [DATA_W-1:0] raw1, abs1, abs2, hi, lo, hi_nxt, lo_nxt, acc_nxt, q_nxt;
  logic [2*DATA_W-1:0] prod, prod_s;

  always_comb begin
    ALUCtrl_o   = ALU_NOP;
    rtype_known = 1'b1;
    md_op       = 1'b0;
    case (ALUOp_i)
      OP_ADD:   ALUCtrl_o = ALU_ADD;
      OP_BEQ:   ALUCtrl_o = ALU_BEQ;
      OP_BNE:   ALUCtrl_o = ALU_BNE;
      OP_ORI:   ALUCtrl_o = ALU_ORI;
      OP_LUI:   ALUCtrl_o = ALU_LUI;
      OP_SLTI:  ALUCtrl_o = ALU_SLT;
      OP_SLTIU: ALUCtrl_o = ALU_SLTU;
      OP_RTYPE: begin
        case (funct_i)
          F_ADD:  ALUCtrl_o = ALU_ADD;
          F_SUB:  ALUCtrl_o = ALU_SUB;
          F_AND:  ALUCtrl_o = ALU_AND;
          F_OR:   ALUCtrl_o = ALU_OR;
          F_SLT:  ALUCtrl_o = ALU_SLT;
          F_SLTU: ALUCtrl_o = ALU_SLTU;
          F_SLL:  ALUCtrl_o = ALU_SLL;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            md_op       = MULDIV_EN;
            rtype_known = MULDIV_EN;
          end
          F_MFHI, F_MFLO: rtype_known = MULDIV_EN;
          default:        rtype_known = 1'b0;
        endcase
      end
    endcase
  end

  assign illegal_o = valid_i && !rtype_known;
  assign issue     = valid_i && md_op;
  assign mf_data_o = (funct_i == F_MFHI) ? hi : lo;
  assign hi_o      = hi;
  assign lo_o      = lo;

  // Unsigned ops feed raw operands; signed ops feed magnitudes and fix the sign on writeback.
  assign div_code = (funct_i == F_DIV) || (funct_i == F_DIVU);
  assign sgn      = (funct_i == F_MULT) || (funct_i == F_DIV);
  assign neg1     = sgn && src1_i[DATA_W-1];
  assign neg2     = sgn && src2_i[DATA_W-1];
  assign abs1     = neg1 ? -src1_i : src1_i;
  assign abs2     = neg2 ? -src2_i : src2_i;

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    start     = 1'b0;
    wr        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          stall_o   = 1'b1;
          start     = 1'b1;
          state_nxt = div_code ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        stall_o = 1'b1;
        if (last) begin
          wr        = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    prod   = {acc_nxt, q_nxt};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    hi_nxt = prod_s[2*DATA_W-1:DATA_W];
    lo_nxt = prod_s[DATA_W-1:0];
    if (state == ST_DIV) begin
      if (div0) begin
        lo_nxt = '1;
        hi_nxt = raw1;
      end else begin
        lo_nxt = (neg_a ^ neg_b) ? -q_nxt : q_nxt;
        hi_nxt = neg_a ? -acc_nxt : acc_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      div0  <= 1'b0;
      raw1  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        neg_a <= neg1;
        neg_b <= neg2;
        div0  <= div_code && (src2_i == '0);
        raw1  <= src1_i;
      end
      if (wr) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
      end
    end
  end

  muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (start),
    .step    ((state == ST_MUL) || (state == ST_DIV)),
    .is_div  (state == ST_DIV),
    .op_a    (abs1),
    .op_b    (abs2),
    .last    (last),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

endmodule
